// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared RV32 core constants, control word type and ID/EX helpers
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] R_TYPE     = 7'b0110011;
   localparam logic [6:0] I_TYPE_ALU = 7'b0010011;
   localparam logic [6:0] I_TYPE_LW  = 7'b0000011;
   localparam logic [6:0] S_TYPE     = 7'b0100011;
   localparam logic [6:0] SB_TYPE    = 7'b1100011;

   localparam logic [1:0] ALUOP_SUB   = 2'b00;
   localparam logic [1:0] ALUOP_ADD   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   typedef struct packed {
      logic [1:0] ALUOp;
      logic       ALUSrc;
      logic       RegWrite;
      logic       MemtoReg;
      logic       MemRead;
      logic       MemWrite;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '{ALUOp: ALUOP_SUB, ALUSrc: 1'b0, RegWrite: 1'b0,
                                     MemtoReg: 1'b0, MemRead: 1'b0, MemWrite: 1'b0};

   typedef enum logic {RUN = 1'b0, PEND = 1'b1} flush_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection for the ID/EX boundary
module hazard_detect
   import cpu_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd_addr,
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       mem_stall,
   output logic       luh,
   output logic       no_op,
   output logic       pc_write,
   output logic       ifid_write
);

   // Matches on address alone; whether the ID instruction really reads rs2 is not decoded here.
   assign luh = ex_mem_read && (ex_rd_addr != 5'd0) &&
                ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

   assign no_op      = luh;
   assign pc_write   = ~luh & ~mem_stall;
   assign ifid_write = ~luh & ~mem_stall;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbles and stall-safe flush; optional HAZARD_CNT_EN counters
module id_ex_stage
   import cpu_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [1:0]      ALUOp_i,
   input  logic            ALUSrc_i,
   input  logic            RegWrite_i,
   input  logic            MemtoReg_i,
   input  logic            MemRead_i,
   input  logic            MemWrite_i,
   input  logic [XLEN-1:0] RS1data_i,
   input  logic [XLEN-1:0] RS2data_i,
   input  logic [XLEN-1:0] Imm_i,
   input  logic [9:0]      funct_i,
   input  logic [4:0]      RS1addr_i,
   input  logic [4:0]      RS2addr_i,
   input  logic [4:0]      RDaddr_i,
   input  logic            flush_i,
   input  logic            mem_stall_i,
   output logic            NoOp_o,
   output logic            PCWrite_o,
   output logic            IFIDWrite_o,
   output logic [1:0]      ALUOp_o,
   output logic            ALUSrc_o,
   output logic            RegWrite_o,
   output logic            MemtoReg_o,
   output logic            MemRead_o,
   output logic            MemWrite_o,
   output logic [XLEN-1:0] RS1data_o,
   output logic [XLEN-1:0] RS2data_o,
   output logic [XLEN-1:0] Imm_o,
   output logic [9:0]      funct_o,
   output logic [4:0]      RS1addr_o,
   output logic [4:0]      RS2addr_o,
   output logic [4:0]      RDaddr_o
`ifdef HAZARD_CNT_EN
   ,
   output logic [31:0]     luh_cnt_o,
   output logic [31:0]     flush_cnt_o,
   output logic [31:0]     stall_cnt_o
`endif
);

   ctrl_t        ctrl_q;
   flush_state_t state;
   logic         luh;
   logic         flush_req;

   hazard_detect u_hazard_detect (
      .ex_mem_read (ctrl_q.MemRead),
      .ex_rd_addr  (RDaddr_o),
      .id_rs1_addr (RS1addr_i),
      .id_rs2_addr (RS2addr_i),
      .mem_stall   (mem_stall_i),
      .luh         (luh),
      .no_op       (NoOp_o),
      .pc_write    (PCWrite_o),
      .ifid_write  (IFIDWrite_o)
   );

   assign flush_req = flush_i | (state == PEND);

   assign ALUOp_o    = ctrl_q.ALUOp;
   assign ALUSrc_o   = ctrl_q.ALUSrc;
   assign RegWrite_o = ctrl_q.RegWrite;
   assign MemtoReg_o = ctrl_q.MemtoReg;
   assign MemRead_o  = ctrl_q.MemRead;
   assign MemWrite_o = ctrl_q.MemWrite;

   // Bubbles zero the address fields too, so RDaddr_o = 0 can never re-raise luh.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q    <= CTRL_BUBBLE;
         RS1data_o <= '0;
         RS2data_o <= '0;
         Imm_o     <= '0;
         funct_o   <= '0;
         RS1addr_o <= '0;
         RS2addr_o <= '0;
         RDaddr_o  <= '0;
         state     <= RUN;
      end else if (mem_stall_i) begin
         if (flush_i) state <= PEND;
      end else if (flush_req || luh) begin
         ctrl_q    <= CTRL_BUBBLE;
         RS1data_o <= '0;
         RS2data_o <= '0;
         Imm_o     <= '0;
         funct_o   <= '0;
         RS1addr_o <= '0;
         RS2addr_o <= '0;
         RDaddr_o  <= '0;
         state     <= RUN;
      end else begin
         ctrl_q    <= '{ALUOp: ALUOp_i, ALUSrc: ALUSrc_i, RegWrite: RegWrite_i,
                        MemtoReg: MemtoReg_i, MemRead: MemRead_i, MemWrite: MemWrite_i};
         RS1data_o <= RS1data_i;
         RS2data_o <= RS2data_i;
         Imm_o     <= Imm_i;
         funct_o   <= funct_i;
         RS1addr_o <= RS1addr_i;
         RS2addr_o <= RS2addr_i;
         RDaddr_o  <= RDaddr_i;
      end
   end

`ifdef HAZARD_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         luh_cnt_o   <= '0;
         flush_cnt_o <= '0;
         stall_cnt_o <= '0;
      end else if (mem_stall_i) begin
         stall_cnt_o <= sat_inc(stall_cnt_o);
      end else if (flush_req) begin
         flush_cnt_o <= sat_inc(flush_cnt_o);
      end else if (luh) begin
         luh_cnt_o   <= sat_inc(luh_cnt_o);
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage; HAZARD_CNT_EN adds counter checks
module tb_id_ex_stage;
   import cpu_pkg::*;

   typedef struct packed {
      logic [1:0]  aluop;
      logic        alusrc;
      logic        regwrite;
      logic        memtoreg;
      logic        memread;
      logic        memwrite;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [9:0]  funct;
      logic [4:0]  rs1a;
      logic [4:0]  rs2a;
      logic [4:0]  rda;
   } ex_t;

   logic clk = 1'b0;
   logic rst_i, flush_i, mem_stall_i;
   ex_t  id, ex_m, dut_ex;
   logic pend_m;
   logic [31:0] luh_c, flush_c, stall_c;

   logic        NoOp_o, PCWrite_o, IFIDWrite_o;
   logic [1:0]  ALUOp_o;
   logic        ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
   logic [31:0] RS1data_o, RS2data_o, Imm_o;
   logic [9:0]  funct_o;
   logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
`ifdef HAZARD_CNT_EN
   logic [31:0] luh_cnt_o, flush_cnt_o, stall_cnt_o;
`endif

   int n_chk = 0;
   int n_fail = 0;
   logic [6:0] ops [5] = '{R_TYPE, I_TYPE_ALU, I_TYPE_LW, S_TYPE, SB_TYPE};

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk_i(clk), .rst_i(rst_i),
      .ALUOp_i(id.aluop), .ALUSrc_i(id.alusrc), .RegWrite_i(id.regwrite),
      .MemtoReg_i(id.memtoreg), .MemRead_i(id.memread), .MemWrite_i(id.memwrite),
      .RS1data_i(id.rs1d), .RS2data_i(id.rs2d), .Imm_i(id.imm), .funct_i(id.funct),
      .RS1addr_i(id.rs1a), .RS2addr_i(id.rs2a), .RDaddr_i(id.rda),
      .flush_i(flush_i), .mem_stall_i(mem_stall_i),
      .NoOp_o(NoOp_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
      .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
      .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
      .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .funct_o(funct_o),
      .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o)
`ifdef HAZARD_CNT_EN
      , .luh_cnt_o(luh_cnt_o), .flush_cnt_o(flush_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
   );

   assign dut_ex = {ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
                    RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Instruction class determines the control word, as the ID decoder would.
   task automatic set_instr(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd);
      id       = '0;
      id.rs1a  = rs1;
      id.rs2a  = rs2;
      id.rda   = rd;
      id.rs1d  = $urandom;
      id.rs2d  = $urandom;
      id.imm   = $urandom;
      id.funct = 10'($urandom);
      case (op)
         R_TYPE:     begin id.aluop = 2'b10; id.regwrite = 1'b1; end
         I_TYPE_ALU: begin id.aluop = 2'b11; id.alusrc = 1'b1; id.regwrite = 1'b1; end
         I_TYPE_LW:  begin id.aluop = 2'b01; id.alusrc = 1'b1; id.regwrite = 1'b1;
                           id.memtoreg = 1'b1; id.memread = 1'b1; end
         S_TYPE:     begin id.aluop = 2'b01; id.alusrc = 1'b1; id.memwrite = 1'b1; end
         default:    begin id.aluop = 2'b00; end
      endcase
   endtask

   function automatic logic model_luh();
      return ex_m.memread && (ex_m.rda != 5'd0) && (ex_m.rda == id.rs1a || ex_m.rda == id.rs2a);
   endfunction

   task automatic model_clear();
      ex_m = '0; pend_m = 1'b0; luh_c = '0; flush_c = '0; stall_c = '0;
   endtask

   task automatic check_comb(input string tag);
      logic hz;
      hz = model_luh();
      chk({tag, "_noop"}, NoOp_o, hz);
      chk({tag, "_pcwrite"}, PCWrite_o, !hz && !mem_stall_i);
      chk({tag, "_ifidwrite"}, IFIDWrite_o, !hz && !mem_stall_i);
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_ex"}, dut_ex, ex_m);
`ifdef HAZARD_CNT_EN
      chk({tag, "_luh_cnt"}, luh_cnt_o, luh_c);
      chk({tag, "_flush_cnt"}, flush_cnt_o, flush_c);
      chk({tag, "_stall_cnt"}, stall_cnt_o, stall_c);
`endif
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic step(input string tag);
      logic hz;
      #3;
      check_comb(tag);
      hz = model_luh();
      @(posedge clk);
      if (mem_stall_i) begin
         if (flush_i) pend_m = 1'b1;
         stall_c++;
      end else if (flush_i || pend_m) begin
         ex_m = '0; pend_m = 1'b0; flush_c++;
      end else if (hz) begin
         ex_m = '0; luh_c++;
      end else begin
         ex_m = id;
      end
      #1;
      check_regs(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 rst_i = 1'b1;
      #1;
      model_clear();
      check_regs({tag, "_now"});
      check_comb({tag, "_now"});
      @(posedge clk);
      #1;
      check_regs({tag, "_held"});
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; mem_stall_i = 1'b0;
      set_instr(R_TYPE, 5'd1, 5'd2, 5'd3);
      model_clear();
      #1;
      check_regs("reset");
      chk("reset_pcwrite", PCWrite_o, 1'b1);
      chk("reset_noop", NoOp_o, 1'b0);
      @(posedge clk);
      #1 rst_i = 1'b0;

      step("capture");
      chk("capture_regwrite", RegWrite_o, 1'b1);
      chk("capture_aluop", ALUOp_o, 2'b10);
      chk("capture_rd", RDaddr_o, 5'd3);

      // load-use: lw x5 then a consumer of x5
      set_instr(I_TYPE_LW, 5'd1, 5'd0, 5'd5);
      step("lw_x5");
      set_instr(R_TYPE, 5'd5, 5'd2, 5'd6);
      #1;
      chk("luh_noop", NoOp_o, 1'b1);
      chk("luh_pcwrite", PCWrite_o, 1'b0);
      chk("luh_ifidwrite", IFIDWrite_o, 1'b0);
      step("luh_bubble");
      chk("luh_bubble_ctrl", {ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}, 7'd0);
      #1;
      chk("luh_after_noop", NoOp_o, 1'b0);
      step("luh_consumer");
      chk("luh_consumer_rd", RDaddr_o, 5'd6);

      // load to x0 never stalls
      set_instr(I_TYPE_LW, 5'd2, 5'd0, 5'd0);
      step("lw_x0");
      set_instr(R_TYPE, 5'd0, 5'd0, 5'd7);
      #1;
      chk("x0_noop", NoOp_o, 1'b0);
      step("x0_consumer");
      chk("x0_consumer_rd", RDaddr_o, 5'd7);

      // flush during a 3-cycle stall
      async_reset("rst_a");
      set_instr(I_TYPE_ALU, 5'd1, 5'd2, 5'd9);
      step("pre_stall");
      mem_stall_i = 1'b1; flush_i = 1'b1;
      set_instr(R_TYPE, 5'd3, 5'd4, 5'd10);
      step("stall1");
      flush_i = 1'b0;
      step("stall2");
      step("stall3");
      chk("stall_held_rd", RDaddr_o, 5'd9);
      mem_stall_i = 1'b0;
      step("pend_bubble");
      chk("pend_bubble_rd", RDaddr_o, 5'd0);
`ifdef HAZARD_CNT_EN
      chk("pend_flush_cnt", flush_cnt_o, 32'd1);
`endif
      step("after_pend");
      chk("after_pend_rd", RDaddr_o, 5'd10);

      // flush and luh together: one bubble, counted as a flush
      set_instr(I_TYPE_LW, 5'd1, 5'd2, 5'd5);
      step("lw_x5b");
      set_instr(R_TYPE, 5'd2, 5'd5, 5'd11);
      flush_i = 1'b1;
      step("flush_luh");
      flush_i = 1'b0;
      chk("flush_luh_rd", RDaddr_o, 5'd0);
      step("flush_luh_next");
      chk("flush_luh_next_rd", RDaddr_o, 5'd11);

      // reset while a flush is pending discards it
      mem_stall_i = 1'b1; flush_i = 1'b1;
      step("to_pend");
      async_reset("rst_pend");
      mem_stall_i = 1'b0; flush_i = 1'b0;
      set_instr(R_TYPE, 5'd1, 5'd2, 5'd12);
      step("post_pend_rst");
      chk("post_pend_rst_rd", RDaddr_o, 5'd12);
`ifdef HAZARD_CNT_EN
      chk("post_pend_rst_flush_cnt", flush_cnt_o, 32'd0);
`endif

      for (int i = 0; i < 400; i++) begin
         set_instr(ops[$urandom_range(0, 4)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         flush_i     = ($urandom_range(0, 9) == 0);
         mem_stall_i = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
         else step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection and flush handling for the 5-stage RV32 core. It sits directly downstream of the ID-stage control decoder and captures its control word together with decoded operands. It drives the decoder's NoOp input and the PC/IF-ID write enables. It inserts bubbles on load-use hazards and flush requests, and freezes under data-memory stall without losing a pending flush.

## Interface
- XLEN, 32, datapath width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- ALUOp_i  in  2  from Control: 00 sub, 01 add, 10 R-type funct, 11 I-type funct
- ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control word from Control
- RS1data_i, RS2data_i, Imm_i  in  XLEN each  ID operands and sign-extended immediate
- funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  5 each  ID register addresses
- flush_i  in  1  kill the ID instruction (replace it with a bubble)
- mem_stall_i  in  1  data-memory busy; freeze the pipeline
- NoOp_o  out  1  to Control; asserted on load-use hazard
- PCWrite_o, IFIDWrite_o  out  1 each  PC and IF/ID write enables
- ALUOp_o … MemWrite_o, RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o  out  same widths  registered EX-stage copies

## Operation
- Load-use hazard is `luh = MemRead_o & (RDaddr_o != 0) & ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i))`. It is combinational on the registered EX state, so the result is the same whether or not the instruction actually reads the operand.
- Combinational outputs:
  - NoOp_o = luh
  - PCWrite_o = IFIDWrite_o = ~luh & ~mem_stall_i
- Register update priority at each edge, highest first:
  1. mem_stall_i: hold every register. If flush_i is also high, set flush_pend.
  2. flush_i | flush_pend: load a bubble and clear flush_pend.
  3. luh: load a bubble.
  4. Otherwise: capture all inputs.
- Bubble: all control outputs = 0 and ALUOp_o = 00. Data and address fields = 0, so RDaddr_o = 0 cannot retrigger luh.
- The bubble is forced internally and does not rely on Control having zeroed its outputs.
- flush_pend state machine:
  - RUN → PEND when mem_stall_i & flush_i.
  - PEND → RUN on the first edge with mem_stall_i low; that edge loads the bubble.
  - PEND + new flush_i: stay in PEND; the two requests merge into one bubble.
- Simultaneous luh and flush_i with no stall: the flush wins and a single bubble is loaded. The following cycle luh is 0 because RDaddr_o = 0.

## Timing
- Latency is 1 cycle from the ID inputs to the EX outputs.
- A load-use hazard costs exactly one bubble cycle. PC and IF/ID hold for that cycle; the dependent instruction enters EX one cycle later.
- Reset values:
  - All registered outputs 0 and flush_pend = 0 (state RUN).
  - NoOp_o = 0; PCWrite_o = IFIDWrite_o = ~mem_stall_i.
- Reset asserted mid-stall or mid-PEND: everything clears immediately and the pending flush is discarded.
- During mem_stall_i, NoOp_o still follows luh, but the register ignores it because the hold has higher priority.

## Configuration
- HAZARD_CNT_EN defined: adds three outputs, each 32 bits, saturating at all-ones, and reset to 0:
  - luh_cnt_o increments on every edge that loads a luh bubble.
  - flush_cnt_o increments on every edge that loads a flush bubble.
  - stall_cnt_o increments on every edge with mem_stall_i high.
- HAZARD_CNT_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (R_TYPE, I_TYPE_ALU, I_TYPE_LW, S_TYPE, SB_TYPE)
  - ALUOp encodings
  - ctrl_t struct {ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite}
  - the constant CTRL_BUBBLE
- One sub-module, hazard_detect: purely combinational. It computes luh, NoOp_o, PCWrite_o and IFIDWrite_o from the EX registers, the ID addresses and mem_stall_i.

## Test plan
- Reset then capture: assert rst_i while the inputs carry the add x3,x1,x2 control word. Require all outputs = 0 and PCWrite_o = 1. Release reset; next edge requires RegWrite_o = 1, ALUOp_o = 10, RDaddr_o = 3.
- Load-use: lw x5 captured, then RS1addr_i = 5. Require NoOp_o = 1 and PCWrite_o = IFIDWrite_o = 0 for one cycle; next edge loads the bubble (all control 0); the cycle after, NoOp_o = 0.
- Load to x0: lw x0 followed by RS1addr_i = 0. Require NoOp_o = 0 and no bubble.
- Flush during stall: mem_stall_i = 1 for 3 cycles with flush_i pulsed in cycle 1. Require outputs held for 3 edges, then exactly one bubble on the first unstalled edge; flush_cnt_o = 1 when HAZARD_CNT_EN is defined.
- Simultaneous flush_i and luh with no stall: require exactly one bubble. With HAZARD_CNT_EN defined, luh_cnt_o unchanged and flush_cnt_o + 1.
- Async reset asserted in PEND: require all outputs 0 within the same cycle, and no bubble-caused count after release.
